// File: rtl/vga_timing_controller.sv
// ============================================================================
// vga_timing_controller
// ----------------------------------------------------------------------------
// Generates the VGA raster for the Pong display. It owns the horizontal and
// vertical pixel counters and decodes sync, blanking and the line/frame
// strobes from them. It also opens a request/acknowledge window for the
// game-logic frame update during vertical blanking and flags updates that
// miss that window.
//
// Optional build macro: VGA_SYNC_PIPE_EN
//   Defined   : hsync, vsync and video_on are delayed by two more clk_div
//               cycles to line up with the 2-stage pixel renderer.
//   Undefined : no extra delay.
//
// Ports
//   clk_div      in   pixel clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   run          in   1 = generate frames, 0 = stop at the next frame boundary
//   update_ack   in   game logic finished its frame update
//   overrun_clr  in   one-cycle pulse clearing the overrun flag
//   h_count      out  horizontal counter, 0..H_TOTAL-1
//   v_count      out  vertical counter, 0..V_TOTAL-1
//   hsync        out  horizontal sync, active low
//   vsync        out  vertical sync, active low
//   video_on     out  1 inside the visible region
//   line_end     out  pulse at h_count = H_TOTAL-1
//   frame_start  out  pulse at (0,0) while running
//   update_req   out  frame update permitted, held until acknowledged
//   overrun      out  sticky: frame update missed the blanking window
// ============================================================================
module vga_timing_controller #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic        clk_div,
    input  logic        reset_n,
    input  logic        run,
    input  logic        update_ack,
    input  logic        overrun_clr,
    output logic [15:0] h_count,
    output logic [15:0] v_count,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic        line_end,
    output logic        frame_start,
    output logic        update_req,
    output logic        overrun
);

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
    // Sync windows as [start, end) pairs
    localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_v;
    logic [CNT_W-1:0] w_h_nxt;
    logic [CNT_W-1:0] w_v_nxt;
    logic             w_h_wrap;
    logic             w_frame_wrap;

    logic             r_hsync;
    logic             r_vsync;
    logic             r_video_on;
    logic             r_line_end;
    logic             r_frame_start;
    logic             r_req;
    logic             r_ovr;

    logic             w_active;
    logic             w_at_origin;
    logic             w_hsync_nxt;
    logic             w_vsync_nxt;
    logic             w_video_on_nxt;
    logic             w_line_end_nxt;
    logic             w_frame_start_nxt;
    logic             w_req_nxt;
    logic             w_ovr_set;
    logic             w_ovr_nxt;

    assign w_h_wrap     = (r_h == H_LAST);
    assign w_frame_wrap = w_h_wrap && (r_v == V_LAST);

    // State register
    always_ff @(posedge clk_div or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and next counter values
    always_comb begin
        w_state_nxt = r_state;
        w_h_nxt     = '0;
        w_v_nxt     = '0;
        case (r_state)
            ST_IDLE: begin
                // Counts stay at 0/0 on the edge that starts the first frame
                if (run) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (!w_h_wrap) begin
                    w_h_nxt = r_h + CNT_W'(1);
                    w_v_nxt = r_v;
                end else if (!w_frame_wrap) begin
                    w_v_nxt = r_v + CNT_W'(1);
                end
                // Stopping only happens on the wrap to (0,0); run returning
                // before then resumes the frame without a break
                if (run) begin
                    w_state_nxt = ST_RUN;
                end else if (w_frame_wrap) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode from next-state values so registered outputs track the counts
    always_comb begin
        w_active          = (w_state_nxt != ST_IDLE);
        w_at_origin       = (w_h_nxt == '0) && (w_v_nxt == '0);
        w_hsync_nxt       = 1'b1;
        w_vsync_nxt       = 1'b1;
        w_video_on_nxt    = 1'b0;
        w_line_end_nxt    = 1'b0;
        w_frame_start_nxt = 1'b0;
        w_req_nxt         = 1'b0;
        w_ovr_set         = 1'b0;
        if (w_active) begin
            w_video_on_nxt    = (w_h_nxt < H_ACT_END) && (w_v_nxt < V_ACT_END);
            w_hsync_nxt       = !((w_h_nxt >= HS_START) && (w_h_nxt < HS_END));
            w_vsync_nxt       = !((w_v_nxt >= VS_START) && (w_v_nxt < VS_END));
            w_line_end_nxt    = (w_h_nxt == H_LAST);
            w_frame_start_nxt = w_at_origin;
            // An unacknowledged request reaching the next frame is an overrun
            if (w_at_origin && r_req && !update_ack) begin
                w_req_nxt = 1'b0;
                w_ovr_set = 1'b1;
            end else if ((w_h_nxt == '0) && (w_v_nxt == V_ACT_END)) begin
                w_req_nxt = 1'b1;
            end else if (update_ack) begin
                w_req_nxt = 1'b0;
            end else begin
                w_req_nxt = r_req;
            end
        end
        // Set has priority over clear
        w_ovr_nxt = w_ovr_set | (r_ovr & ~overrun_clr);
    end

    // Counter and output registers
    always_ff @(posedge clk_div or negedge reset_n) begin
        if (!reset_n) begin
            r_h           <= '0;
            r_v           <= '0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_video_on    <= 1'b0;
            r_line_end    <= 1'b0;
            r_frame_start <= 1'b0;
            r_req         <= 1'b0;
            r_ovr         <= 1'b0;
        end else begin
            r_h           <= w_h_nxt;
            r_v           <= w_v_nxt;
            r_hsync       <= w_hsync_nxt;
            r_vsync       <= w_vsync_nxt;
            r_video_on    <= w_video_on_nxt;
            r_line_end    <= w_line_end_nxt;
            r_frame_start <= w_frame_start_nxt;
            r_req         <= w_req_nxt;
            r_ovr         <= w_ovr_nxt;
        end
    end

`ifdef VGA_SYNC_PIPE_EN
    // Two extra stages to align sync/blank with the renderer pipeline
    logic [1:0] r_hs_pipe;
    logic [1:0] r_vs_pipe;
    logic [1:0] r_vo_pipe;

    always_ff @(posedge clk_div or negedge reset_n) begin
        if (!reset_n) begin
            r_hs_pipe <= 2'b11;
            r_vs_pipe <= 2'b11;
            r_vo_pipe <= 2'b00;
        end else begin
            r_hs_pipe <= {r_hs_pipe[0], r_hsync};
            r_vs_pipe <= {r_vs_pipe[0], r_vsync};
            r_vo_pipe <= {r_vo_pipe[0], r_video_on};
        end
    end

    assign hsync    = r_hs_pipe[1];
    assign vsync    = r_vs_pipe[1];
    assign video_on = r_vo_pipe[1];
`else
    assign hsync    = r_hsync;
    assign vsync    = r_vsync;
    assign video_on = r_video_on;
`endif

    assign h_count     = r_h;
    assign v_count     = r_v;
    assign line_end    = r_line_end;
    assign frame_start = r_frame_start;
    assign update_req  = r_req;
    assign overrun     = r_ovr;

endmodule

// File: tb/tb_vga_timing_controller.sv
// ============================================================================
// tb_vga_timing_controller
// ----------------------------------------------------------------------------
// Self-checking bench for vga_timing_controller, run on a shrunken raster
// (32 x 21) so several frames fit in a short run. The reference model tracks
// the raster as a single linear position within the frame plus a running flag
// and derives every expected output from that position arithmetically.
// ============================================================================
module tb_vga_timing_controller;

    localparam int unsigned HA = 16;
    localparam int unsigned HF = 4;
    localparam int unsigned HS = 6;
    localparam int unsigned HB = 6;
    localparam int unsigned VA = 12;
    localparam int unsigned VF = 3;
    localparam int unsigned VS = 2;
    localparam int unsigned VB = 4;
    localparam int unsigned HT = HA + HF + HS + HB;
    localparam int unsigned VT = VA + VF + VS + VB;
    localparam int unsigned FT = HT * VT;

`ifdef VGA_SYNC_PIPE_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif

    localparam logic [38:0] RESET_VEC = {16'd0, 16'd0, 7'b1100000};

    logic        clk_div     = 1'b0;
    logic        reset_n     = 1'b0;
    logic        run         = 1'b0;
    logic        update_ack  = 1'b0;
    logic        overrun_clr = 1'b0;
    logic [15:0] h_count;
    logic [15:0] v_count;
    logic        hsync;
    logic        vsync;
    logic        video_on;
    logic        line_end;
    logic        frame_start;
    logic        update_req;
    logic        overrun;

    vga_timing_controller #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
    ) dut (
        .clk_div     (clk_div),
        .reset_n     (reset_n),
        .run         (run),
        .update_ack  (update_ack),
        .overrun_clr (overrun_clr),
        .h_count     (h_count),
        .v_count     (v_count),
        .hsync       (hsync),
        .vsync       (vsync),
        .video_on    (video_on),
        .line_end    (line_end),
        .frame_start (frame_start),
        .update_req  (update_req),
        .overrun     (overrun)
    );

    always #5 clk_div = ~clk_div;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    bit          m_act;
    int unsigned m_pos;
    bit          m_req;
    bit          m_ovr;
    bit          m_fs;
    bit          m_le;
    bit [2:0]    m_sync;   // {hsync, vsync, video_on} as seen at the ports
    bit [2:0]    m_q0;
    bit [2:0]    m_q1;
    logic [38:0] m_vec;

    function automatic logic [38:0] dut_vec();
        return {h_count, v_count, hsync, vsync, video_on,
                line_end, frame_start, update_req, overrun};
    endfunction

    function automatic bit [2:0] decode(bit act, int unsigned pos);
        int unsigned h = pos % HT;
        int unsigned v = pos / HT;
        bit [2:0] d;
        d[2] = !(act && h >= HA + HF && h < HA + HF + HS);
        d[1] = !(act && v >= VA + VF && v < VA + VF + VS);
        d[0] = act && h < HA && v < VA;
        return d;
    endfunction

    task automatic build_vec();
        m_vec = {16'(m_pos % HT), 16'(m_pos / HT), m_sync, m_le, m_fs, m_req, m_ovr};
    endtask

    task automatic model_reset();
        m_act  = 1'b0;
        m_pos  = 0;
        m_req  = 1'b0;
        m_ovr  = 1'b0;
        m_fs   = 1'b0;
        m_le   = 1'b0;
        m_q0   = 3'b110;
        m_q1   = 3'b110;
        m_sync = 3'b110;
        build_vec();
    endtask

    // One rising edge of the raster, given the inputs sampled at that edge
    task automatic model_edge(input bit r, input bit a, input bit c);
        bit          nact;
        int unsigned np;
        bit          set;
        bit [2:0]    d;
        if (!m_act) begin
            nact = r;
            np   = 0;
        end else begin
            np   = (m_pos + 1) % FT;
            nact = !(np == 0 && !r);
        end
        set = 1'b0;
        if (!nact)                          m_req = 1'b0;
        else if (np == 0 && m_req && !a)    begin m_req = 1'b0; set = 1'b1; end
        else if (np == VA * HT)             m_req = 1'b1;
        else if (a)                         m_req = 1'b0;
        m_ovr = set | (m_ovr & !c);
        m_act = nact;
        m_pos = np;
        m_fs  = nact && np == 0;
        m_le  = nact && (np % HT == HT - 1);
        d     = decode(nact, np);
        if (PIPE) begin
            m_sync = m_q1;
            m_q1   = m_q0;
            m_q0   = d;
        end else begin
            m_sync = d;
        end
        build_vec();
    endtask

    task automatic step();
        bit r = run;
        bit a = update_ack;
        bit c = overrun_clr;
        @(posedge clk_div);
        if (reset_n) model_edge(r, a, c);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; run = 1'b0; update_ack = 1'b0; overrun_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_div);
        #1;
        n_total++;
        if (dut_vec() !== RESET_VEC) $display("FAIL reset_vals: got %h exp %h", dut_vec(), RESET_VEC);
        else n_pass++;
        reset_n = 1'b1;
        repeat (5) begin
            step();
            n_total++;
            if (dut_vec() !== m_vec) $display("FAIL idle_hold: got %h exp %h", dut_vec(), m_vec);
            else n_pass++;
        end
    endtask

    task automatic test_first_line();
        int hs_low = 0;
        int hs_first = -1;
        int le_cnt = 0;
        run = 1'b1;
        step();
        n_total++;
        if ({h_count, v_count, frame_start, video_on} !== {16'd0, 16'd0, 1'b1, !PIPE})
            $display("FAIL first_edge: got h=%0d v=%0d fs=%b vo=%b", h_count, v_count, frame_start, video_on);
        else n_pass++;
        repeat (HT) begin
            step();
            n_total++;
            if (dut_vec() !== m_vec) $display("FAIL line_cmp: got %h exp %h", dut_vec(), m_vec);
            else n_pass++;
            if (hsync === 1'b0) begin
                if (hs_first < 0) hs_first = int'(h_count);
                hs_low++;
            end
            if (line_end === 1'b1) le_cnt++;
        end
        n_total++;
        if (hs_low != int'(HS)) $display("FAIL hsync_width: got %0d exp %0d", hs_low, HS);
        else n_pass++;
        n_total++;
        if (hs_first != int'(HA + HF) + (PIPE ? 2 : 0))
            $display("FAIL hsync_start: got %0d exp %0d", hs_first, int'(HA + HF) + (PIPE ? 2 : 0));
        else n_pass++;
        n_total++;
        if (le_cnt != 1) $display("FAIL line_end_cnt: got %0d exp 1", le_cnt);
        else n_pass++;
    endtask

    task automatic test_frames();
        int vs_low = 0;
        int fs_cnt = 0;
        int last_fs = -1;
        int gap = -1;
        for (int i = 0; i < int'(2 * FT); i++) begin
            step();
            n_total++;
            if (dut_vec() !== m_vec) $display("FAIL frame_cmp: got %h exp %h", dut_vec(), m_vec);
            else n_pass++;
            if (vsync === 1'b0) vs_low++;
            if (frame_start === 1'b1) begin
                n_total++;
                if ({h_count, v_count} !== 32'd0) $display("FAIL fs_pos: got h=%0d v=%0d exp 0,0", h_count, v_count);
                else n_pass++;
                if (last_fs >= 0) gap = i - last_fs;
                last_fs = i;
                fs_cnt++;
            end
        end
        n_total++;
        if (vs_low != int'(2 * VS * HT)) $display("FAIL vsync_width: got %0d exp %0d", vs_low, 2 * VS * HT);
        else n_pass++;
        n_total++;
        if (fs_cnt != 2 || gap != int'(FT)) $display("FAIL frame_period: got cnt=%0d gap=%0d exp 2,%0d", fs_cnt, gap, FT);
        else n_pass++;
    endtask

    task automatic test_handshake();
        run = 1'b1;
        for (int i = 0; i < int'(2 * FT) && update_req !== 1'b0; i++) begin
            step();
            n_total++;
            if (dut_vec() !== m_vec) $display("FAIL hs_wait0: got %h exp %h", dut_vec(), m_vec);
            else n_pass++;
        end
        for (int i = 0; i < int'(2 * FT) && update_req !== 1'b1; i++) begin
            step();
            n_total++;
            if (dut_vec() !== m_vec) $display("FAIL hs_wait1: got %h exp %h", dut_vec(), m_vec);
            else n_pass++;
        end
        n_total++;
        if ({update_req, h_count, v_count} !== {1'b1, 16'd0, 16'(VA)})
            $display("FAIL req_rise: got req=%b h=%0d v=%0d exp 1,0,%0d", update_req, h_count, v_count, VA);
        else n_pass++;
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        repeat (10) begin
            step();
            n_total++;
            if (dut_vec() !== m_vec) $display("FAIL req_hold: got %h exp %h", dut_vec(), m_vec);
            else n_pass++;
        end
        update_ack = 1'b1;
        step();
        update_ack = 1'b0;
        n_total++;
        if ({update_req, overrun} !== 2'b00) $display("FAIL req_ack: got req=%b ovr=%b exp 0,0", update_req, overrun);
        else n_pass++;
        // Ack with no request outstanding must do nothing
        update_ack = 1'b1;
        step();
        update_ack = 1'b0;
        n_total++;
        if (dut_vec() !== m_vec) $display("FAIL stray_ack: got %h exp %h", dut_vec(), m_vec);
        else n_pass++;
    endtask

    task automatic test_overrun();
        run = 1'b1;
        for (int i = 0; i < int'(2 * FT) && update_req !== 1'b1; i++) begin
            step();
            n_total++;
            if (dut_vec() !== m_vec) $display("FAIL ov_wait_req: got %h exp %h", dut_vec(), m_vec);
            else n_pass++;
        end
        for (int i = 0; i < int'(2 * FT) && frame_start !== 1'b1; i++) begin
            step();
            n_total++;
            if (dut_vec() !== m_vec) $display("FAIL ov_wait_fs: got %h exp %h", dut_vec(), m_vec);
            else n_pass++;
        end
        n_total++;
        if ({update_req, overrun} !== 2'b01) $display("FAIL overrun_set: got req=%b ovr=%b exp 0,1", update_req, overrun);
        else n_pass++;
        repeat (3) step();
        n_total++;
        if (overrun !== 1'b1) $display("FAIL overrun_sticky: got %b exp 1", overrun);
        else n_pass++;
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        n_total++;
        if (overrun !== 1'b0) $display("FAIL overrun_clr: got %b exp 0", overrun);
        else n_pass++;
        // Wait for the last pixel of the frame, then clear on the overrun edge
        for (int i = 0; i < int'(2 * FT) && !(h_count === 16'(HT - 1) && v_count === 16'(VT - 1)); i++) begin
            step();
            n_total++;
            if (dut_vec() !== m_vec) $display("FAIL ov_wait_end: got %h exp %h", dut_vec(), m_vec);
            else n_pass++;
        end
        n_total++;
        if (update_req !== 1'b1) $display("FAIL req_pending: got %b exp 1", update_req);
        else n_pass++;
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        n_total++;
        if ({frame_start, update_req, overrun} !== 3'b101)
            $display("FAIL set_wins: got fs=%b req=%b ovr=%b exp 1,0,1", frame_start, update_req, overrun);
        else n_pass++;
    endtask

    task automatic test_drain();
        run = 1'b1;
        for (int i = 0; i < int'(2 * FT) && !(h_count === 16'd9 && v_count === 16'd6); i++) step();
        n_total++;
        if ({h_count, v_count} !== {16'd9, 16'd6}) $display("FAIL drain_reach: got h=%0d v=%0d exp 9,6", h_count, v_count);
        else n_pass++;
        run = 1'b0;
        repeat (FT - (6 * HT + 9)) begin
            step();
            n_total++;
            if (dut_vec() !== m_vec) $display("FAIL drain_cmp: got %h exp %h", dut_vec(), m_vec);
            else n_pass++;
        end
        n_total++;
        if ({h_count, v_count, hsync, vsync, frame_start, update_req} !== {16'd0, 16'd0, 4'b1100})
            $display("FAIL drain_stop: got h=%0d v=%0d hs=%b vs=%b fs=%b req=%b", h_count, v_count, hsync, vsync, frame_start, update_req);
        else n_pass++;
        repeat (10) begin
            step();
            n_total++;
            if (dut_vec() !== m_vec) $display("FAIL idle_stay: got %h exp %h", dut_vec(), m_vec);
            else n_pass++;
        end
        // Re-raise run in DRAIN: the frame keeps going through the wrap
        run = 1'b1;
        for (int i = 0; i < int'(2 * FT) && !(h_count === 16'd9 && v_count === 16'd2); i++) step();
        run = 1'b0;
        for (int i = 0; i < int'(2 * FT) && !(h_count === 16'd5 && v_count === 16'd3); i++) step();
        n_total++;
        if ({h_count, v_count} !== {16'd5, 16'd3}) $display("FAIL drain_count: got h=%0d v=%0d exp 5,3", h_count, v_count);
        else n_pass++;
        run = 1'b1;
        repeat (FT - (3 * HT + 5)) begin
            step();
            n_total++;
            if (dut_vec() !== m_vec) $display("FAIL resume_cmp: got %h exp %h", dut_vec(), m_vec);
            else n_pass++;
        end
        n_total++;
        if ({h_count, v_count, frame_start} !== {16'd0, 16'd0, 1'b1})
            $display("FAIL resume_wrap: got h=%0d v=%0d fs=%b exp 0,0,1", h_count, v_count, frame_start);
        else n_pass++;
        step();
        n_total++;
        if ({h_count, v_count} !== {16'd1, 16'd0}) $display("FAIL resume_go: got h=%0d v=%0d exp 1,0", h_count, v_count);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) run = ~run;
            update_ack  = ($urandom_range(0, 39) == 0);
            overrun_clr = ($urandom_range(0, 79) == 0);
            step();
            n_total++;
            if (dut_vec() !== m_vec) $display("FAIL random_cmp: cyc=%0d got %h exp %h", i, dut_vec(), m_vec);
            else n_pass++;
        end
        update_ack = 1'b0;
        overrun_clr = 1'b0;
    endtask

    task automatic test_async_reset();
        run = 1'b1;
        for (int i = 0; i < int'(2 * FT) && !(h_count === 16'd22 && v_count === 16'd16); i++) step();
        n_total++;
        if ({h_count, v_count} !== {16'd22, 16'd16}) $display("FAIL ar_reach: got h=%0d v=%0d exp 22,16", h_count, v_count);
        else n_pass++;
        #2;
        reset_n = 1'b0;
        #1;
        n_total++;
        if (dut_vec() !== RESET_VEC) $display("FAIL async_reset: got %h exp %h", dut_vec(), RESET_VEC);
        else n_pass++;
        model_reset();
        step();
        reset_n = 1'b1;
        repeat (40) begin
            step();
            n_total++;
            if (dut_vec() !== m_vec) $display("FAIL post_reset: got %h exp %h", dut_vec(), m_vec);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_first_line();
        test_frames();
        test_handshake();
        test_overrun();
        test_drain();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule
